cat_anim_ctrl: RTL and testbench
================================

# cat_anim_ctrl

Throw-animation sequencer for the cat player sprite. Accepts a throw request, steps the cat through four poses (idle, wind-up, throw, recover) at a rate locked to VGA frame boundaries, and drives the pose select that the cat draw stage uses to pick one of its four sprite ROM outputs. It emits a single-cycle release pulse with the latched throw power to the projectile logic. Sits between game input/control logic and the cat draw stage, in the 60 MHz pixel clock domain.

## Interface
- FRAMES_PER_POSE, 8, number of frame ticks each non-idle pose is held; legal range 1..255
- PWR_W, 4, width of throw power field

- clk60MHz  in  1  pixel clock
- rst_n  in  1  reset; asynchronous, active-low
- vblnk  in  1  vertical blanking from VGA timing; rising edge = frame tick
- throw_req  in  1  level request to start a throw
- throw_power  in  PWR_W  power, sampled when a request is accepted
- throw_ack  out  1  one-cycle pulse, request accepted
- pose_sel  out  2  0 idle, 1 wind-up, 2 throw, 3 recover; to the draw stage sprite mux
- busy  out  1  high in any state other than IDLE
- release_pulse  out  1  one-cycle pulse on entry to THROW
- release_power  out  PWR_W  latched power; valid while release_pulse=1, holds value otherwise

## Operation
- Frame tick: vblnk_d is vblnk registered. tick = vblnk & ~vblnk_d. The tick is combinational in the first cycle vblnk is high.
- Frame counter fcnt has width $clog2(FRAMES_PER_POSE+1). It is used only in WINDUP, THROW and RECOVER.
- States: IDLE, WINDUP, THROW, RECOVER. pose_sel is 0, 1, 2, 3 respectively.
- IDLE: if throw_req=1, the block takes the following actions:
  - latch throw_power into release_power
  - pulse throw_ack
  - clear fcnt
  - go to WINDUP
- In IDLE, ticks are ignored.
- Non-idle state, tick with fcnt==FRAMES_PER_POSE-1: clear fcnt and advance state.
- Non-idle state, tick otherwise: increment fcnt.
- Non-idle state, no tick: hold.
- Transitions are WINDUP->THROW, THROW->RECOVER, RECOVER->IDLE.
- The WINDUP->THROW transition asserts release_pulse for exactly one cycle.
- Requests arriving while busy=1 are ignored: no ack, no latch, not queued.
- A tick in the same cycle as an accepted request does not count. fcnt is 0 after that edge.
- If throw_req stays high through a whole throw, the block re-accepts it in the first IDLE cycle.
- Each pose lasts exactly FRAMES_PER_POSE ticks. A full throw lasts 3*FRAMES_PER_POSE ticks plus at least one IDLE cycle.

## Timing
- All outputs are registered. They update on the same clk60MHz edge as the state change.
- Request latency: throw_req sampled high in IDLE at edge k gives state=WINDUP, pose_sel=1, busy=1 and throw_ack=1 after edge k. throw_ack drops after edge k+1.
- Tick latency: a qualifying tick sampled at edge k puts the new pose_sel after edge k. This is one cycle after vblnk rises, so the pose changes during blanking.
- Reset (rst_n=0, asynchronous, also mid-throw) forces the following values immediately:
  - state=IDLE, fcnt=0, vblnk_d=0
  - pose_sel=0, busy=0
  - throw_ack=0, release_pulse=0, release_power=0
- Release from reset with vblnk already high: vblnk_d=0, so a tick occurs in the first cycle. It is harmless because the block is in IDLE.

## Configuration
- CAT_ANIM_AUTOREPEAT_EN defined: at the RECOVER exit tick, if throw_req=1, the block does not pass through IDLE. On that edge it does the following:
  - go directly to WINDUP
  - pulse throw_ack
  - re-latch throw_power
  - clear fcnt
- The same applies with FRAMES_PER_POSE=1.
- CAT_ANIM_AUTOREPEAT_EN undefined: RECOVER always exits to IDLE. A repeat requires at least one IDLE cycle.

## Test plan
- Reset, then no requests and ticks every 1000 cycles -> pose_sel=0, busy=0, no pulses for 10 ticks.
- FRAMES_PER_POSE=2, throw_req high for 1 cycle with power=0xA -> the following response:
  - throw_ack one cycle after the request edge
  - pose_sel goes 1 (2 ticks), 2 (2 ticks), 3 (2 ticks), then 0
  - release_pulse once, with release_power=0xA
  - busy low after tick 6
- Request with power=5 while in THROW -> no ack, release_power stays at the earlier value, sequence timing unchanged.
- Request and vblnk rising edge in the same IDLE cycle -> WINDUP lasts a full 2 ticks after the accept, not 1.
- rst_n pulsed low mid-RECOVER, asynchronous to the clock -> all outputs go to 0 immediately; after release, the next request starts a clean WINDUP.
- throw_req held high constantly, FRAMES_PER_POSE=1 -> the response depends on the macro:
  - without the macro: one IDLE cycle (pose_sel=0) between throws, an ack per throw
  - with CAT_ANIM_AUTOREPEAT_EN: pose_sel goes 3 -> 1 with no 0 in between, an ack per throw

Source files
------------

// File: rtl/cat_anim_ctrl.sv
// cat_anim_ctrl: throw-animation sequencer for the cat sprite.
// Steps IDLE -> WINDUP -> THROW -> RECOVER -> IDLE. Each non-idle pose is
// held for FRAMES_PER_POSE frame ticks, where a frame tick is the rising
// edge of vblnk. Throw power is latched when a request is accepted and is
// presented with a one-cycle release pulse on entry to THROW.
//
// Parameters:
//   FRAMES_PER_POSE  frame ticks per non-idle pose (1..255)
//   PWR_W            throw power width
// Ports:
//   clk60MHz       in   pixel clock
//   rst_n          in   asynchronous active-low reset
//   vblnk          in   vertical blanking; rising edge = frame tick
//   throw_req      in   level request to start a throw
//   throw_power    in   power, sampled on request accept
//   throw_ack      out  one-cycle pulse, request accepted
//   pose_sel       out  0 idle, 1 wind-up, 2 throw, 3 recover
//   busy           out  high whenever not idle
//   release_pulse  out  one-cycle pulse on entry to THROW
//   release_power  out  latched throw power
// Build option:
//   CAT_ANIM_AUTOREPEAT_EN  a held request at the RECOVER exit tick goes
//                           straight to WINDUP without an IDLE cycle.
module cat_anim_ctrl #(
  parameter int unsigned FRAMES_PER_POSE = 8,
  parameter int unsigned PWR_W           = 4
) (
  input  logic             clk60MHz,
  input  logic             rst_n,
  input  logic             vblnk,
  input  logic             throw_req,
  input  logic [PWR_W-1:0] throw_power,
  output logic             throw_ack,
  output logic [1:0]       pose_sel,
  output logic             busy,
  output logic             release_pulse,
  output logic [PWR_W-1:0] release_power
);

  localparam int unsigned FCNT_W = $clog2(FRAMES_PER_POSE + 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAMES_PER_POSE - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WINDUP  = 2'd1,
    S_THROW   = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [FCNT_W-1:0]  fcnt, fcnt_n;
  logic               vblnk_d;
  logic               tick;
  logic               busy_q;
  logic               ack_q, ack_n;
  logic               rel_q, rel_n;
  logic [PWR_W-1:0]   pwr_q, pwr_n;

  assign tick = vblnk & ~vblnk_d;

  always_ff @(posedge clk60MHz or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      fcnt    <= '0;
      vblnk_d <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      rel_q   <= 1'b0;
      pwr_q   <= '0;
    end else begin
      state   <= state_n;
      fcnt    <= fcnt_n;
      vblnk_d <= vblnk;
      busy_q  <= (state_n != S_IDLE);
      ack_q   <= ack_n;
      rel_q   <= rel_n;
      pwr_q   <= pwr_n;
    end
  end

  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    ack_n   = 1'b0;
    rel_n   = 1'b0;
    pwr_n   = pwr_q;
    if (state == S_IDLE) begin
      // Ticks are ignored here, so a tick coinciding with the accept
      // does not count toward the wind-up pose.
      if (throw_req) begin
        state_n = S_WINDUP;
        fcnt_n  = '0;
        ack_n   = 1'b1;
        pwr_n   = throw_power;
      end
    end else if (tick) begin
      if (fcnt == FCNT_LAST) begin
        fcnt_n = '0;
        case (state)
          S_WINDUP: begin
            state_n = S_THROW;
            rel_n   = 1'b1;
          end
          S_THROW:  state_n = S_RECOVER;
          default: begin
`ifdef CAT_ANIM_AUTOREPEAT_EN
            if (throw_req) begin
              state_n = S_WINDUP;
              ack_n   = 1'b1;
              pwr_n   = throw_power;
            end else begin
              state_n = S_IDLE;
            end
`else
            state_n = S_IDLE;
`endif
          end
        endcase
      end else begin
        fcnt_n = fcnt + FCNT_W'(1);
      end
    end
  end

  assign pose_sel      = state;
  assign busy          = busy_q;
  assign throw_ack     = ack_q;
  assign release_pulse = rel_q;
  assign release_power = pwr_q;

endmodule

// File: tb/tb_cat_anim_ctrl.sv
module tb_cat_anim_ctrl;

  logic       clk60MHz = 1'b0;
  logic       rst_n    = 1'b1;
  logic       vblnk    = 1'b0;

  logic       throw_req   = 1'b0;
  logic [3:0] throw_power = 4'h0;
  logic       throw_ack, busy, release_pulse;
  logic [1:0] pose_sel;
  logic [3:0] release_power;

  logic       throw_req1   = 1'b0;
  logic [3:0] throw_power1 = 4'h0;
  logic       throw_ack1, busy1, release_pulse1;
  logic [1:0] pose_sel1;
  logic [3:0] release_power1;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0, rel_cnt = 0, ack1_cnt = 0, rel1_cnt = 0;

  always #5 clk60MHz = ~clk60MHz;

  cat_anim_ctrl #(.FRAMES_PER_POSE(2), .PWR_W(4)) dut (
    .clk60MHz(clk60MHz), .rst_n(rst_n), .vblnk(vblnk),
    .throw_req(throw_req), .throw_power(throw_power),
    .throw_ack(throw_ack), .pose_sel(pose_sel), .busy(busy),
    .release_pulse(release_pulse), .release_power(release_power)
  );

  cat_anim_ctrl #(.FRAMES_PER_POSE(1), .PWR_W(4)) dut1 (
    .clk60MHz(clk60MHz), .rst_n(rst_n), .vblnk(vblnk),
    .throw_req(throw_req1), .throw_power(throw_power1),
    .throw_ack(throw_ack1), .pose_sel(pose_sel1), .busy(busy1),
    .release_pulse(release_pulse1), .release_power(release_power1)
  );

  always @(negedge clk60MHz) begin
    if (throw_ack === 1'b1)      ack_cnt++;
    if (release_pulse === 1'b1)  rel_cnt++;
    if (throw_ack1 === 1'b1)     ack1_cnt++;
    if (release_pulse1 === 1'b1) rel1_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk60MHz);
    #1;
  endtask

  // Low for one edge, then high: the second edge sees the tick.
  task automatic frame_tick();
    vblnk = 1'b0;
    step();
    vblnk = 1'b1;
    step();
  endtask

  task automatic chk_main(input string tag, input int pose, input int bsy);
    chk({tag, "_pose"}, 32'(pose_sel), 32'(pose));
    chk({tag, "_busy"}, 32'(busy), 32'(bsy));
  endtask

  initial begin
    // Asynchronous reset before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pose",  32'(pose_sel), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_ack",   32'(throw_ack), 0);
    chk("rst_rel",   32'(release_pulse), 0);
    chk("rst_power", 32'(release_power), 0);
    vblnk = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    // Tick right after reset release is ignored in IDLE
    step();
    chk_main("post_rst", 0, 0);

    // Idle ticks spaced 1000 cycles apart
    for (int i = 0; i < 10; i++) begin
      vblnk = 1'b0;
      repeat (500) step();
      vblnk = 1'b1;
      repeat (500) step();
      chk_main("idle_tick", 0, 0);
    end
    chk("idle_ack_cnt", 32'(ack_cnt), 0);
    chk("idle_rel_cnt", 32'(rel_cnt), 0);

    // Basic throw, power 0xA
    throw_req = 1'b1; throw_power = 4'hA;
    step();
    throw_req = 1'b0; throw_power = 4'h0;
    chk("acc_ack", 32'(throw_ack), 1);
    chk_main("acc", 1, 1);
    chk("acc_power", 32'(release_power), 32'hA);
    step();
    chk("ack_drop", 32'(throw_ack), 0);
    chk_main("wind_hold", 1, 1);
    frame_tick();
    chk_main("t1", 1, 1);
    frame_tick();
    chk_main("t2", 2, 1);
    chk("t2_rel", 32'(release_pulse), 1);
    chk("t2_power", 32'(release_power), 32'hA);
    step();
    chk("rel_drop", 32'(release_pulse), 0);
    frame_tick();
    chk_main("t3", 2, 1);
    // Request while busy is ignored
    throw_req = 1'b1; throw_power = 4'h5;
    step();
    throw_req = 1'b0; throw_power = 4'h0;
    chk("busy_req_ack", 32'(throw_ack), 0);
    chk("busy_req_power", 32'(release_power), 32'hA);
    frame_tick();
    chk_main("t4", 3, 1);
    frame_tick();
    chk_main("t5", 3, 1);
    frame_tick();
    chk_main("t6", 0, 0);
    chk("throw_power_hold", 32'(release_power), 32'hA);
    chk("throw_ack_cnt", 32'(ack_cnt), 1);
    chk("throw_rel_cnt", 32'(rel_cnt), 1);

    // Request coinciding with a tick: that tick must not count
    vblnk = 1'b0;
    step();
    vblnk = 1'b1; throw_req = 1'b1; throw_power = 4'hC;
    step();
    throw_req = 1'b0;
    chk("coin_ack", 32'(throw_ack), 1);
    chk_main("coin_acc", 1, 1);
    frame_tick();
    chk_main("coin_t1", 1, 1);
    frame_tick();
    chk_main("coin_t2", 2, 1);
    chk("coin_rel_power", 32'(release_power), 32'hC);
    frame_tick();
    frame_tick();
    frame_tick();
    frame_tick();
    chk_main("coin_end", 0, 0);

    // Asynchronous reset mid-RECOVER
    throw_req = 1'b1; throw_power = 4'h6;
    step();
    throw_req = 1'b0;
    repeat (4) frame_tick();
    chk_main("pre_rst_recover", 3, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_main("mid_rst", 0, 0);
    chk("mid_rst_ack", 32'(throw_ack), 0);
    chk("mid_rst_rel", 32'(release_pulse), 0);
    chk("mid_rst_power", 32'(release_power), 0);
    #3 rst_n = 1'b1;
    step();
    chk_main("rst_rel_idle", 0, 0);
    throw_req = 1'b1; throw_power = 4'h3;
    step();
    throw_req = 1'b0;
    chk("clean_ack", 32'(throw_ack), 1);
    chk_main("clean_acc", 1, 1);
    chk("clean_power", 32'(release_power), 32'h3);
    frame_tick();
    chk_main("clean_t1", 1, 1);
    frame_tick();
    chk_main("clean_t2", 2, 1);
    chk("clean_t2_rel", 32'(release_pulse), 1);
    repeat (4) frame_tick();
    chk_main("clean_end", 0, 0);

    // FRAMES_PER_POSE=1 with the request held high
    throw_req1 = 1'b1; throw_power1 = 4'h7;
    step();
    chk("f1_ack", 32'(throw_ack1), 1);
    chk("f1_pose_acc", 32'(pose_sel1), 1);
    frame_tick();
    chk("f1_pose_t1", 32'(pose_sel1), 2);
    chk("f1_rel_t1", 32'(release_pulse1), 1);
    chk("f1_power", 32'(release_power1), 32'h7);
    frame_tick();
    chk("f1_pose_t2", 32'(pose_sel1), 3);
    frame_tick();
`ifdef CAT_ANIM_AUTOREPEAT_EN
    chk("f1_rep_pose", 32'(pose_sel1), 1);
    chk("f1_rep_ack", 32'(throw_ack1), 1);
    chk("f1_rep_busy", 32'(busy1), 1);
`else
    chk("f1_gap_pose", 32'(pose_sel1), 0);
    chk("f1_gap_busy", 32'(busy1), 0);
    chk("f1_gap_ack", 32'(throw_ack1), 0);
    step();
    chk("f1_rep_pose", 32'(pose_sel1), 1);
    chk("f1_rep_ack", 32'(throw_ack1), 1);
`endif
    frame_tick();
    chk("f1_pose_t4", 32'(pose_sel1), 2);
    frame_tick();
    chk("f1_pose_t5", 32'(pose_sel1), 3);
    throw_req1 = 1'b0;
    frame_tick();
    chk("f1_pose_end", 32'(pose_sel1), 0);
    chk("f1_ack_cnt", 32'(ack1_cnt), 2);
    chk("f1_rel_cnt", 32'(rel1_cnt), 2);
    chk("main_idle_during_f1", 32'(pose_sel), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
